// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state encoding and latency helpers derived from WIDTH/MUL_BITS.
package mdu_pkg;

  localparam logic [2:0] MDU_OP_MULTU = 3'b000;
  localparam logic [2:0] MDU_OP_MULT  = 3'b001;
  localparam logic [2:0] MDU_OP_DIVU  = 3'b010;
  localparam logic [2:0] MDU_OP_DIV   = 3'b011;
  localparam logic [2:0] MDU_OP_MADDU = 3'b100;
  localparam logic [2:0] MDU_OP_MADD  = 3'b101;
  localparam logic [2:0] MDU_OP_MSUBU = 3'b110;
  localparam logic [2:0] MDU_OP_MSUB  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } mdu_state_t;

  // Cycles spent in the MUL state.
  function automatic int mul_iters(input int width, input int mul_bits);
    return width / mul_bits;
  endfunction

  // Edges from start acceptance to the result write (busy length).
  function automatic int mul_latency(input int width, input int mul_bits);
    return width / mul_bits + 1;
  endfunction

  function automatic int div_latency(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Restoring divider on unsigned magnitudes: one quotient bit per cycle,
// WIDTH cycles per divide; kill aborts an in-flight divide.
module mdu_div_core
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             kill,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             last,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = $clog2(WIDTH);

  logic             running;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvsr_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // quo_q starts as the dividend and shifts quotient bits in from the right.
  assign shifted   = {rem_q, quo_q[WIDTH-1]};
  assign diff      = shifted - {1'b0, dvsr_q};
  assign last      = running & (cnt == CNT_W'(WIDTH - 1));
  assign quotient  = quo_q;
  assign remainder = rem_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      running <= 1'b0;
      cnt     <= '0;
      dvsr_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else if (kill) begin
      running <= 1'b0;
      cnt     <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      dvsr_q  <= divisor;
      quo_q   <= dividend;
      rem_q   <= '0;
    end else if (running) begin
      if (!diff[WIDTH]) begin
        rem_q <= diff[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_q <= shifted[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end
      cnt <= cnt + 1'b1;
      if (last) running <= 1'b0;
    end
  end

endmodule

// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit owning HI/LO. Build option MDU_MADD_EN
// enables the madd/msub accumulate ops (op 1xx); otherwise they are ignored.
module mdu_iterative
  import mdu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic             cancel,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output mdu_state_t       dbg_state
);

  localparam int MUL_ITERS = mul_iters(WIDTH, MUL_BITS);
  localparam int MCNT_W    = $clog2(MUL_ITERS) + 1;
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  mdu_state_t          state;
  logic [WIDTH-1:0]    mcand_q;
  logic [2*WIDTH-1:0]  prod_q;
  logic [MCNT_W-1:0]   mcnt_q;
  logic                is_div_q;
  logic                neg_q;
  logic                neg_r;
  logic                special_q;
  logic [WIDTH-1:0]    spec_hi_q;
  logic [WIDTH-1:0]    spec_lo_q;
`ifdef MDU_MADD_EN
  logic                acc_q;
  logic                sub_q;
`endif

  // Handshake: start is taken only at an edge where the unit is IDLE (busy
  // low) and no cancel/mthi/mtlo is present; busy then stays high until the
  // edge that writes HI/LO and pulses done. Starts while busy are dropped.
  logic             sign_a, sign_b, op_is_div, op_legal, accept;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             div_by_zero, div_ovf;

  assign sign_a      = op[0] & src_a[WIDTH-1];
  assign sign_b      = op[0] & src_b[WIDTH-1];
  assign mag_a       = sign_a ? -src_a : src_a;
  assign mag_b       = sign_b ? -src_b : src_b;
  assign op_is_div   = (op[2:1] == 2'b01);
`ifdef MDU_MADD_EN
  assign op_legal    = 1'b1;
`else
  assign op_legal    = ~op[2];
`endif
  assign accept      = (state == ST_IDLE) & start & ~cancel & ~mthi & ~mtlo & op_legal;
  assign div_by_zero = (src_b == '0);
  assign div_ovf     = op[0] & (src_a == SMIN) & (src_b == '1);

  logic             div_last;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;

  mdu_div_core #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .reset     (reset),
    .kill      (cancel),
    .start     (accept & op_is_div),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .last      (div_last),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // prod_q holds {partial_high, multiplier}; each cycle retires MUL_BITS of
  // the multiplier from the bottom and shifts the partial sum in at the top.
  logic [WIDTH+MUL_BITS-1:0] mul_partial;

  always_comb begin
    mul_partial = {{MUL_BITS{1'b0}}, prod_q[2*WIDTH-1:WIDTH]};
    for (int i = 0; i < MUL_BITS; i++) begin
      if (prod_q[i]) mul_partial = mul_partial + ({{MUL_BITS{1'b0}}, mcand_q} << i);
    end
  end

  logic [2*WIDTH-1:0] prod_fixed, mul_result, fix_val;
  logic [WIDTH-1:0]   quo_fixed, rem_fixed;

  assign prod_fixed = neg_q ? -prod_q : prod_q;
  assign quo_fixed  = neg_q ? -div_quo : div_quo;
  assign rem_fixed  = neg_r ? -div_rem : div_rem;
`ifdef MDU_MADD_EN
  assign mul_result = !acc_q ? prod_fixed :
                      sub_q  ? ({hi, lo} - prod_fixed) : ({hi, lo} + prod_fixed);
`else
  assign mul_result = prod_fixed;
`endif
  assign fix_val    = !is_div_q ? mul_result :
                      special_q ? {spec_hi_q, spec_lo_q} : {rem_fixed, quo_fixed};

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      hi        <= '0;
      lo        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mcand_q   <= '0;
      prod_q    <= '0;
      mcnt_q    <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      special_q <= 1'b0;
      spec_hi_q <= '0;
      spec_lo_q <= '0;
`ifdef MDU_MADD_EN
      acc_q     <= 1'b0;
      sub_q     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!cancel && mthi) hi <= src_a;
          if (!cancel && mtlo) lo <= src_a;
          if (accept) begin
            state     <= op_is_div ? ST_DIV : ST_MUL;
            busy      <= 1'b1;
            mcand_q   <= mag_a;
            prod_q    <= {{WIDTH{1'b0}}, mag_b};
            mcnt_q    <= '0;
            is_div_q  <= op_is_div;
            neg_q     <= sign_a ^ sign_b;
            neg_r     <= sign_a;
            // Divide corner cases are fixed now but still run full latency.
            special_q <= op_is_div & (div_by_zero | div_ovf);
            spec_hi_q <= div_by_zero ? src_a : '0;
            spec_lo_q <= div_by_zero ? '1 : SMIN;
`ifdef MDU_MADD_EN
            acc_q     <= op[2];
            sub_q     <= op[1];
`endif
          end
        end
        ST_MUL: begin
          if (cancel) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            prod_q <= {mul_partial, prod_q[WIDTH-1:MUL_BITS]};
            mcnt_q <= mcnt_q + 1'b1;
            if (mcnt_q == MCNT_W'(MUL_ITERS - 1)) state <= ST_FIX;
          end
        end
        ST_DIV: begin
          if (cancel) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (div_last) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          if (!cancel) begin
            hi   <= fix_val[2*WIDTH-1:WIDTH];
            lo   <= fix_val[WIDTH-1:0];
            done <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative (WIDTH=32, MUL_BITS=4): directed
// vector table, random scoreboarded ops, and cancel/move/reset sequences.
module tb_mdu_iterative;
  import mdu_pkg::*;

  logic        clk, reset, start, mthi, mtlo, cancel;
  logic [2:0]  op;
  logic [31:0] src_a, src_b, hi, lo;
  logic        busy, done;
  mdu_state_t  dbg_state;

  mdu_iterative #(.WIDTH(32), .MUL_BITS(4)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .mthi(mthi), .mtlo(mtlo), .cancel(cancel), .hi(hi), .lo(lo), .busy(busy),
    .done(done), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard: every done pops one expected {hi,lo}
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got hi=%h lo=%h expected no done", hi, lo);
      end else begin
        check("result_hilo", {hi, lo}, exp_q.pop_front());
      end
    end
  end

  // Reference model, written directly from the architectural definitions.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint x, y;
    int sa, sb;
    case (o[1:0])
      2'b00: return {32'b0, a} * {32'b0, b};
      2'b01: begin
        x = longint'($signed(a));
        y = longint'($signed(b));
        return 64'(x * y);
      end
      2'b10: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sa = $signed(a);
        sb = $signed(b);
        return {32'(sa % sb), 32'(sa / sb)};
      end
    endcase
  endfunction

  // driver: call at a negedge; returns at the negedge of the done cycle
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp_v, input int exp_n, input int poke);
    int n;
    op = o; src_a = a; src_b = b; start = 1'b1;
    exp_q.push_back(exp_v);
    @(posedge clk);
    #1;
    start = 1'b0;
    src_a = $urandom;
    src_b = $urandom;
    op = 3'($urandom_range(0, 7));
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      start = 1'b0;
      mtlo = 1'b0;
      if (!busy) break;
      n++;
      if (n == 3 && poke == 1) start = 1'b1;
      if (n == 3 && poke == 2) mtlo = 1'b1;
    end
    check("busy_cycles", 64'(n), 64'(exp_n));
    check("done_at_busy_fall", 64'(done), 64'd1);
  endtask

  task automatic do_ignored(input logic [2:0] o, input logic [63:0] keep_v);
    bit seen_busy;
    seen_busy = 1'b0;
    op = o; src_a = 32'd1; src_b = 32'd1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      seen_busy |= busy;
    end
    check("ignored_op_busy", 64'(seen_busy), 64'd0);
    check("ignored_op_hilo", {hi, lo}, keep_v);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          n;
    int          poke;
    bit          b2b;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int n;
    bit seen;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    tbl[0] = '{MDU_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 9, 0, 1'b0};
    tbl[1] = '{MDU_OP_MULT,  32'hFFFF_FFFD, 32'd7,        64'hFFFF_FFFF_FFFF_FFEB, 9, 1, 1'b0};
    tbl[2] = '{MDU_OP_DIV,   32'hFFFF_FFF9, 32'd2,        64'hFFFF_FFFF_FFFF_FFFD, 33, 0, 1'b0};
    tbl[3] = '{MDU_OP_DIVU,  32'd9,         32'd4,        64'h0000_0001_0000_0002, 33, 0, 1'b1};
    tbl[4] = '{MDU_OP_DIVU,  32'h1234_5678, 32'd0,        64'h1234_5678_FFFF_FFFF, 33, 0, 1'b0};
    tbl[5] = '{MDU_OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 33, 0, 1'b0};
    tbl[6] = '{MDU_OP_MULT,  32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 9, 0, 1'b1};
    tbl[7] = '{MDU_OP_DIV,   32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 33, 2, 1'b0};
    tbl[8] = '{MDU_OP_DIV,   32'hFFFF_FFF9, 32'd0,        64'hFFFF_FFF9_FFFF_FFFF, 33, 0, 1'b1};
    tbl[9] = '{MDU_OP_MULTU, 32'd0,         32'h0001_2345, 64'h0, 9, 0, 1'b0};

    reset = 1'b1; start = 1'b0; op = 3'd0; src_a = '0; src_b = '0;
    mthi = 1'b0; mtlo = 1'b0; cancel = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);

    // directed vectors
    for (int i = 0; i < 10; i++) begin
      if (!tbl[i].b2b) @(negedge clk);
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].n, tbl[i].poke);
    end

    // random back-to-back mul/div against the model
    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) - 32'd20 : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 10)) - 32'd5 : $urandom;
      do_op(ro, ra, rb, model(ro, ra, rb), ro[1] ? 33 : 9, 0);
    end

    // mthi in IDLE, no done
    @(negedge clk);
    mthi = 1'b1; src_a = 32'hAAAA_AAAA;
    @(posedge clk);
    #1 mthi = 1'b0;
    @(negedge clk);
    check("mthi_hi", 64'(hi), 64'hAAAA_AAAA);
    check("mthi_no_done", 64'(done), 64'd0);

    // mtlo with start in the same cycle: move wins, start dropped
    mtlo = 1'b1; start = 1'b1; op = MDU_OP_DIVU; src_a = 32'h55; src_b = 32'd3;
    @(posedge clk);
    #1 mtlo = 1'b0; start = 1'b0;
    @(negedge clk);
    check("move_beats_start_lo", 64'(lo), 64'h55);
    check("move_beats_start_busy", 64'(busy), 64'd0);

    // div 100/7 cancelled in the 10th busy cycle
    op = MDU_OP_DIV; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy) n++;
      if (n == 10) break;
    end
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_busy", 64'(busy), 64'd0);
    check("cancel_hilo", {hi, lo}, {32'hAAAA_AAAA, 32'h55});
    seen = done;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      seen |= done;
    end
    check("cancel_no_done", 64'(seen), 64'd0);

    // cancel in IDLE suppresses a same-cycle start
    cancel = 1'b1; start = 1'b1; op = MDU_OP_MULTU; src_a = 32'd5; src_b = 32'd5;
    @(posedge clk);
    #1 cancel = 1'b0; start = 1'b0;
    @(negedge clk);
    check("idle_cancel_busy", 64'(busy), 64'd0);
    check("idle_cancel_state", 64'(dbg_state), 64'(ST_IDLE));

    // accumulate ops from hi=0, lo=all ones
    mthi = 1'b1; src_a = 32'd0;
    @(posedge clk);
    #1 mthi = 1'b0;
    @(negedge clk);
    mtlo = 1'b1; src_a = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 mtlo = 1'b0;
    @(negedge clk);
`ifdef MDU_MADD_EN
    do_op(MDU_OP_MADDU, 32'd1, 32'd1, 64'h0000_0001_0000_0000, 9, 0);
    do_op(MDU_OP_MSUB, 32'hFFFF_FFFF, 32'd1, 64'h0000_0001_0000_0001, 9, 0);
`else
    do_ignored(MDU_OP_MADDU, 64'h0000_0000_FFFF_FFFF);
    do_ignored(MDU_OP_MSUB, 64'h0000_0000_FFFF_FFFF);
`endif

    // reset in the middle of a multiply clears HI/LO and aborts
    @(negedge clk);
    op = MDU_OP_MULTU; src_a = 32'd3; src_b = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midop_reset_hilo", {hi, lo}, 64'd0);
    check("midop_reset_busy", 64'(busy), 64'd0);
    repeat (20) @(negedge clk);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish before 2ms");
    $fatal(1);
  end

endmodule
